// File: rtl/interrupt_service_controller_if.sv
// rtl/interrupt_service_controller_if.sv - CPU-side interrupt handshake and EOI bundle
interface interrupt_service_controller_if #(
    parameter int NUM_IRQ = 16,
    parameter int VEC_W   = 8
);
    logic [NUM_IRQ-1:0] grantSignals;
    logic               intAck;
    logic               eoi;
    logic               eoiSpecific;
    logic [3:0]         eoiLevel;
    logic               intReq;
    logic               vectorValid;
    logic [VEC_W-1:0]   vector;
    logic [NUM_IRQ-1:0] pendingClear;
    logic [NUM_IRQ-1:0] inService;

    modport master (
        output grantSignals, intAck, eoi, eoiSpecific, eoiLevel,
        input  intReq, vectorValid, vector, pendingClear, inService
    );

    modport slave (
        input  grantSignals, intAck, eoi, eoiSpecific, eoiLevel,
        output intReq, vectorValid, vector, pendingClear, inService
    );
endinterface

// File: rtl/interrupt_service_controller.sv
// rtl/interrupt_service_controller.sv - nesting interrupt handshake FSM with in-service register
module interrupt_service_controller #(
    parameter int               NUM_IRQ      = 16,
    parameter int               VEC_W        = 8,
    parameter logic [VEC_W-1:0] VECTOR_BASE  = 8'h20,
    parameter logic [VEC_W-1:0] SPURIOUS_VEC = 8'hFF
) (
    input  logic                          clkPort,
    input  logic                          Reset,
    interrupt_service_controller_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_IRQ);

    typedef enum logic [1:0] {IDLE, REQ, DELIVER, RELEASE} state_t;

    state_t             r_state;
    logic               r_int_req;
    logic               r_vector_valid;
    logic [VEC_W-1:0]   r_vector;
    logic [NUM_IRQ-1:0] r_pending_clear;
    logic [NUM_IRQ-1:0] r_isr;

    logic [IDX_W-1:0]   w_hi_idx;
    logic               w_isr_any;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_grant_any;
    logic [NUM_IRQ-1:0] w_grant_oh;
    logic               w_eligible;
    logic [NUM_IRQ-1:0] w_eoi_clr;
    logic [NUM_IRQ-1:0] w_isr_set;
    logic               w_take;

    // Descending scan so the last hit is the lowest index, i.e. highest priority.
    always_comb begin
        w_hi_idx    = '0;
        w_isr_any   = 1'b0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (r_isr[i]) begin
                w_hi_idx  = i[IDX_W-1:0];
                w_isr_any = 1'b1;
            end
            if (bus.grantSignals[i]) begin
                w_grant_idx = i[IDX_W-1:0];
                w_grant_any = 1'b1;
            end
        end
    end

    assign w_grant_oh = w_grant_any ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << w_grant_idx) : '0;
    assign w_eligible = w_grant_any && (!w_isr_any || (w_grant_idx < w_hi_idx));
    assign w_take     = (r_state == REQ) && bus.intAck;
    assign w_isr_set  = w_take ? w_grant_oh : '0;

    // Non-specific EOI isolates the lowest set ISR bit of the pre-update register.
    always_comb begin
        w_eoi_clr = '0;
        if (bus.eoi) begin
            if (bus.eoiSpecific)
                w_eoi_clr = {{(NUM_IRQ-1){1'b0}}, 1'b1} << bus.eoiLevel;
            else
                w_eoi_clr = r_isr & (~r_isr + {{(NUM_IRQ-1){1'b0}}, 1'b1});
        end
    end

    always_ff @(posedge clkPort) begin
        if (Reset) begin
            r_state         <= IDLE;
            r_int_req       <= 1'b0;
            r_vector_valid  <= 1'b0;
            r_vector        <= '0;
            r_pending_clear <= '0;
            r_isr           <= '0;
        end else begin
            // Set applied after clear so a coincident EOI on the same bit loses.
            r_isr           <= (r_isr & ~w_eoi_clr) | w_isr_set;
            r_vector_valid  <= 1'b0;
            r_pending_clear <= '0;
            case (r_state)
                IDLE: begin
                    if (w_eligible) begin
                        r_state   <= REQ;
                        r_int_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.intAck) begin
                        r_state        <= DELIVER;
                        r_int_req      <= 1'b0;
                        r_vector_valid <= 1'b1;
                        if (w_grant_any) begin
                            r_vector        <= VECTOR_BASE + VEC_W'(w_grant_idx);
                            r_pending_clear <= w_grant_oh;
                        end else begin
                            r_vector <= SPURIOUS_VEC;
                        end
                    end else if (!w_eligible) begin
                        r_state   <= IDLE;
                        r_int_req <= 1'b0;
                    end
                end
                DELIVER: r_state <= RELEASE;
                RELEASE: begin
                    if (!bus.intAck)
                        r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_int_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.intReq       = r_int_req;
    assign bus.vectorValid  = r_vector_valid;
    assign bus.vector       = r_vector;
    assign bus.pendingClear = r_pending_clear;
    assign bus.inService    = r_isr;
endmodule

// File: doc/interrupt_service_controller.md
Name: interrupt_service_controller

Overview:
- Consumes the one-hot grant from the 16-input priority resolver and runs the CPU interrupt handshake: raise request, wait for acknowledge, deliver vector, record in-service level, clear the serviced pending request upstream.
- Holds the in-service register (ISR) and enforces nesting, so only a grant of strictly higher priority than every in-service level is forwarded.
- Retires levels on end-of-interrupt (EOI) commands from the CPU side.
- Priority: bit 0 highest, bit 15 lowest.

Parameters:
- NUM_IRQ, 16, number of interrupt lines; grant/ISR width.
- VEC_W, 8, vector width.
- VECTOR_BASE, 8'h20, vector for level 0; level i delivers VECTOR_BASE+i (mod 2^VEC_W).
- SPURIOUS_VEC, 8'hFF, vector delivered when acknowledge finds no grant.

Ports:
- clkPort  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- grantSignals  in  NUM_IRQ  one-hot (or zero) grant from the priority resolver.
- intAck  in  1  CPU acknowledge, level; held high until vector taken.
- eoi  in  1  one-cycle EOI strobe.
- eoiSpecific  in  1  qualifies eoi: 1 = specific, 0 = non-specific.
- eoiLevel  in  4  level cleared by a specific EOI.
- intReq  out  1  interrupt request to CPU.
- vectorValid  out  1  one-cycle strobe, vector valid.
- vector  out  VEC_W  interrupt vector, held until next vectorValid.
- pendingClear  out  NUM_IRQ  one-cycle one-hot pulse clearing the serviced bit in the upstream request register.
- inService  out  NUM_IRQ  current ISR contents.

Behaviour:
Register and sampling rules:
- All outputs registered. Reset sampled on rising clkPort edge.
- On Reset: state=IDLE, intReq=0, vectorValid=0, vector=0, pendingClear=0, inService=0.
- Reset mid-handshake abandons the handshake: no vector, no ISR update. Reset overrides all other inputs.

Eligibility:
- hiISR = lowest set index in ISR; none if ISR=0.
- grant is eligible when it is non-zero AND (ISR=0 OR grant index < hiISR).
- A grant at or below hiISR is ignored until EOI retires the blocking level.

FSM states: IDLE, REQ, DELIVER, RELEASE.
- IDLE: if grant eligible -> REQ, intReq=1 from next cycle. Latency from grant to intReq is 1 cycle.
- REQ: grant is re-evaluated every cycle.
  - If it becomes ineligible or zero while intAck=0: -> IDLE, intReq=0 next cycle (request withdrawn, no vector).
  - If intAck=1: capture the current grant, -> DELIVER, intReq=0.
- DELIVER: one cycle, vectorValid=1.
  - Captured grant index i: vector=VECTOR_BASE+i, ISR[i] set, pendingClear[i]=1 for this cycle only.
  - Captured grant zero (spurious): vector=SPURIOUS_VEC, no ISR change, pendingClear=0.
  - Always -> RELEASE.
- RELEASE: wait for intAck=0, then -> IDLE. No new request can be raised until intAck drops.
- intAck high in IDLE is ignored.

EOI:
- Evaluated in any state except during Reset; takes effect at the same edge it is sampled.
- Non-specific: clears the lowest-index set ISR bit; no effect if ISR=0.
- Specific: clears ISR[eoiLevel]; no effect if already clear.
- EOI selection uses the pre-update ISR.
- EOI in the same cycle as a DELIVER set: both apply. If both target the same bit, the set wins.
- An EOI that lowers hiISR can make a held grant eligible; IDLE acts on it the following cycle.

Invariants:
- vectorValid and pendingClear never assert outside DELIVER.
- intReq is never high in DELIVER or RELEASE.
- ISR bits change only via DELIVER or EOI.

Test Plan:
- Reset, then grant=16'h0008, intAck raised 2 cycles after intReq -> intReq high 1 cycle after grant; next cycle after intAck sampled: vectorValid=1, vector=8'h23, pendingClear=16'h0008, inService=16'h0008.
- With inService=16'h0008, grant=16'h0010 -> intReq stays 0. Then grant=16'h0002 -> full handshake, vector=8'h21, inService=16'h000A.
- inService=16'h000A, eoi=1, eoiSpecific=0 -> inService=16'h0008. Then specific eoi, eoiLevel=3 -> inService=0.
- Grant 16'h0004 raises intReq; grant drops to 0 before intAck -> intReq falls next cycle. A later intAck gives no vectorValid. Variant with intAck in the same cycle the grant drops -> vector=8'hFF, inService unchanged.
- Reset asserted in REQ with intAck pending -> next cycle all outputs 0, state IDLE, no vectorValid.
- DELIVER of level 5 coincident with non-specific EOI while ISR=16'h0040 -> ISR=16'h0020.
